// File: rtl/clock_divider_prog_pkg.sv
// clock_divider_prog_pkg: shared state encoding and default counter width
package clock_divider_prog_pkg;
  localparam int CNT_W_DEF = 28;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/clock_divider_prog_pending.sv
// div_pending_reg: captures a clamped divisor and holds it until the top applies it
module div_pending_reg
  import clock_divider_prog_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             apply_i,
  input  logic [CNT_W-1:0] div_i,
  output logic [CNT_W-1:0] pend_o,
  output logic             pend_v_o
);
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  // OR-ing in the zero flag turns 0 into 1 and leaves every other value untouched
  always_comb begin
    pend_d   = load_i ? (div_i | {{(CNT_W-1){1'b0}}, div_i == '0}) : pend_q;
    pend_v_d = load_i | (pend_v_q & ~apply_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end
  assign pend_o   = pend_q;
  assign pend_v_o = pend_v_q;
endmodule

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable integer divider producing CLK_OUT and a per-period TICK
module clock_divider_prog
  import clock_divider_prog_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [CNT_W-1:0] DIV_IN,
  input  logic             DIV_LOAD,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             LOAD_PEND,
  output logic [CNT_W-1:0] DIV_ACT
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_act_q, div_act_d, pend;
  logic             clk_q, clk_d, tick_q, tick_d;
  logic             pend_v, last, start, apply;
  logic [CNT_W:0]   hi, cnt_inc;
  div_pending_reg #(.CNT_W(CNT_W)) u_pend (
    .clk_i   (CLK_IN),
    .rst_ni  (RST_N),
    .load_i  (DIV_LOAD),
    .apply_i (apply),
    .div_i   (DIV_IN),
    .pend_o  (pend),
    .pend_v_o(pend_v)
  );
  assign last    = cnt_q == div_act_q - 1'b1;
  assign hi      = ({1'b0, div_act_q} + 1'b1) >> 1;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign start   = (state_q == ST_IDLE) ? EN : last & EN;
  // Idle always accepts a pending divisor; a run only switches at a continuing boundary
  assign apply   = (state_q == ST_IDLE) | start;
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_act_q <= CNT_W'(DEFAULT_DIV);
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (EN ? ST_RUN : ST_IDLE) : ((last && !EN) ? ST_IDLE : ST_RUN);
  end
  always_comb begin
    cnt_d     = (state_q == ST_RUN && !last) ? cnt_q + 1'b1 : '0;
    clk_d     = start ? 1'b1 : (state_q == ST_RUN && !last) ? (cnt_inc < hi) : 1'b0;
    tick_d    = start;
    div_act_d = (apply && pend_v) ? pend : div_act_q;
  end
  assign CLK_OUT   = clk_q;
  assign TICK      = tick_q;
  assign LOAD_PEND = pend_v;
  assign DIV_ACT   = div_act_q;
endmodule
